// File: rtl/demux16x8_wb.sv
// rtl/demux16x8_wb.sv - LC-3b register-file write side with per-register busy scoreboard.
// Optional same-cycle write-through forwarding on q0..q7 when DEMUX16X8_WB_BYPASS_EN is defined.
module demux16x8_wb #(
  parameter int unsigned            WIDTH     = 16,
  parameter logic [WIDTH-1:0]       RESET_VAL = 16'h0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [2:0]       wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_byte,
  input  logic             set_busy,
  input  logic [2:0]       set_sel,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [WIDTH-1:0] q4,
  output logic [WIDTH-1:0] q5,
  output logic [WIDTH-1:0] q6,
  output logic [WIDTH-1:0] q7,
  output logic [7:0]       busy,
  output logic             wr_err
);

  logic [WIDTH-1:0] regs_q [8];
  logic [WIDTH-1:0] regs_d [8];
  logic [WIDTH-1:0] rd     [8];
  logic [7:0]       busy_q, busy_d;
  logic             wr_err_q, wr_err_d;
  logic [WIDTH-1:0] wr_val;

  // LDB-style byte writes sign-extend bit 7 across the upper bits.
  assign wr_val = wr_byte ? {{(WIDTH-8){wr_data[7]}}, wr_data[7:0]} : wr_data;

  always_comb begin
    regs_d   = regs_q;
    busy_d   = busy_q;
    wr_err_d = 1'b0;
    if (wr_en) begin
      regs_d[wr_sel] = wr_val;
      busy_d[wr_sel] = 1'b0;
      wr_err_d       = ~busy_q[wr_sel];
    end
    // Issue wins over retire so a new producer on the same register stays pending.
    if (set_busy) begin
      busy_d[set_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= RESET_VAL;
      end
      busy_q   <= 8'h00;
      wr_err_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      busy_q   <= busy_d;
      wr_err_q <= wr_err_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
`ifdef DEMUX16X8_WB_BYPASS_EN
      rd[i] = (wr_en && (wr_sel == 3'(i))) ? wr_val : regs_q[i];
`else
      rd[i] = regs_q[i];
`endif
    end
  end

  assign q0     = rd[0];
  assign q1     = rd[1];
  assign q2     = rd[2];
  assign q3     = rd[3];
  assign q4     = rd[4];
  assign q5     = rd[5];
  assign q6     = rd[6];
  assign q7     = rd[7];
  assign busy   = busy_q;
  assign wr_err = wr_err_q;

endmodule

// File: tb/tb_demux16x8_wb.sv
// tb/tb_demux16x8_wb.sv - scoreboard bench for demux16x8_wb with a behavioural register-file model.
module tb_demux16x8_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en, wr_byte, set_busy;
  logic [2:0]  wr_sel, set_sel;
  logic [15:0] wr_data;
  logic [15:0] q0, q1, q2, q3, q4, q5, q6, q7;
  logic [7:0]  busy;
  logic        wr_err;
  logic [15:0] qa [8];

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0][15:0] r;
    logic [7:0]       b;
    logic             e;
  } exp_t;

  exp_t             sb [$];
  logic [7:0][15:0] m_r;
  logic [7:0]       m_b;

  always #5 clk = ~clk;

  demux16x8_wb dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .wr_byte(wr_byte), .set_busy(set_busy), .set_sel(set_sel),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5), .q6(q6), .q7(q7),
    .busy(busy), .wr_err(wr_err)
  );

  always_comb begin
    qa[0] = q0; qa[1] = q1; qa[2] = q2; qa[3] = q3;
    qa[4] = q4; qa[5] = q5; qa[6] = q6; qa[7] = q7;
  end

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one expected snapshot per clock edge following an issued cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int i = 0; i < 8; i++) begin
          check16($sformatf("q%0d", i), qa[i], e.r[i]);
        end
        check16("busy", {8'h00, busy}, {8'h00, e.b});
        check16("wr_err", {15'h0, wr_err}, {15'h0, e.e});
      end
    end
  end

  task automatic issue(input logic en, input logic [2:0] sel, input logic [15:0] data,
                       input logic byt, input logic sbz, input logic [2:0] ssel);
    logic [15:0] wv;
    exp_t        e;
    @(negedge clk);
    wr_en = en; wr_sel = sel; wr_data = data; wr_byte = byt; set_busy = sbz; set_sel = ssel;
    wv = byt ? {{8{data[7]}}, data[7:0]} : data;
    e.e = en && !m_b[sel];
    #1;
    if (en) begin
`ifdef DEMUX16X8_WB_BYPASS_EN
      check16("bypass_q", qa[sel], wv);
`else
      check16("nobypass_q", qa[sel], m_r[sel]);
`endif
    end
    if (en) begin
      m_r[sel] = wv;
      m_b[sel] = 1'b0;
    end
    if (sbz) m_b[ssel] = 1'b1;
    e.r = m_r;
    e.b = m_b;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
    m_b = 8'h00;
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 8; i++) check16($sformatf("%s_q%0d", tag, i), qa[i], 16'h0000);
    check16({tag, "_busy"}, {8'h00, busy}, 16'h0000);
    check16({tag, "_err"}, {15'h0, wr_err}, 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_sel = 3'd0; wr_data = 16'h0; wr_byte = 1'b0;
    set_busy = 1'b0; set_sel = 3'd0;
    model_reset();
    #1;
    check_reset_state("init");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    issue(0, 3'd0, 16'h0000, 0, 1, 3'd5);
    issue(1, 3'd5, 16'hBEEF, 0, 0, 3'd0);
    issue(0, 3'd0, 16'h0000, 0, 0, 3'd0);
    issue(1, 3'd2, 16'h12F0, 1, 0, 3'd0);
    issue(1, 3'd2, 16'hAB7F, 1, 0, 3'd0);
    issue(0, 3'd0, 16'h0000, 0, 1, 3'd4);
    issue(1, 3'd4, 16'h0042, 0, 1, 3'd4);
    issue(1, 3'd1, 16'h0007, 0, 0, 3'd0);
    issue(0, 3'd0, 16'h0000, 0, 0, 3'd0);
    issue(0, 3'd0, 16'h0000, 0, 0, 3'd0);
    for (int n = 0; n < 8; n++) issue(1, 3'(n), 16'h1000 + 16'(n), 0, 0, 3'd0);
    issue(0, 3'd0, 16'h0000, 0, 0, 3'd0);

    for (int k = 0; k < 400; k++) begin
      issue(1'($urandom % 2), 3'($urandom % 8), 16'($urandom), 1'($urandom % 2),
            1'($urandom % 2), 3'($urandom % 8));
    end

    issue(1, 3'd3, 16'h1234, 0, 1, 3'd6);
    @(posedge clk);
    #3;
    wr_en = 1'b1; wr_sel = 3'd3; wr_data = 16'h5555; wr_byte = 1'b0;
    set_busy = 1'b1; set_sel = 3'd2;
    reset = 1'b1;
    model_reset();
    #1;
    wr_en = 1'b0;
    #1;
    check_reset_state("async");
    @(posedge clk);
    #1;
    check_reset_state("held");
    @(negedge clk);
    reset = 1'b0; set_busy = 1'b0;

    for (int k = 0; k < 100; k++) begin
      issue(1'($urandom % 2), 3'($urandom % 8), 16'($urandom), 1'($urandom % 2),
            1'($urandom % 2), 3'($urandom % 8));
    end
    issue(0, 3'd0, 16'h0000, 0, 0, 3'd0);
    @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_drain: got %0d entries expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux16x8_wb.md
Name: demux16x8_wb

Overview:
- Register-file write side for the LC-3b datapath; the write-steering counterpart of the 8:1 16-bit read mux.
- Takes one write-back value plus a 3-bit destination and updates exactly one of eight 16-bit registers.
- Registers are exposed in parallel as q0..q7, which feed the read mux inputs data0..data7.
- Keeps a per-register pending ("busy") scoreboard so issue logic can stall on read-after-write hazards.

Parameters:
- WIDTH, 16, register/data width; must be >= 9 because byte mode sign-extends bit 7.
- RESET_VAL, 16'h0000, value loaded into every register on reset.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- wr_en  input  1  write-back strobe; one write per cycle when high
- wr_sel  input  3  destination register index 0..7
- wr_data  input  WIDTH  write-back value
- wr_byte  input  1  1 = write sign-extended wr_data[7:0] (LDB-style); 0 = write full word
- set_busy  input  1  issue strobe: mark register set_sel as pending
- set_sel  input  3  register index being marked pending
- q0..q7  output  WIDTH each  current register contents
- busy  output  8  pending flag per register; bit n corresponds to qn
- wr_err  output  1  registered one-cycle pulse: write to a register whose busy bit was clear

Behaviour:
- Reset (asynchronous, active-high):
  - q0..q7 = RESET_VAL, busy = 8'h00, wr_err = 0.
  - Applies immediately, including mid-operation; any write on the reset-release edge is not taken if reset is still high at that edge.
- Write:
  - On a rising clk with wr_en = 1, only register wr_sel updates; the other seven hold.
  - Write data:
    - wr_byte = 0: value = wr_data.
    - wr_byte = 1: value = {(WIDTH-8){wr_data[7]}, wr_data[7:0]}; upper bits of wr_data are ignored.
  - Latency: the new value is visible on q[wr_sel] one cycle after the write edge (registered, no forwarding unless BYPASS_EN).
- Scoreboard:
  - set_busy = 1 sets busy[set_sel] on the edge.
  - wr_en = 1 clears busy[wr_sel] on the edge.
  - set_busy and wr_en to different registers in the same cycle: both take effect.
  - set_busy and wr_en to the same register in the same cycle: the data write happens and the busy bit ends up SET (new producer issued).
  - set_busy on an already-busy register: stays 1, no error.
- Error:
  - wr_err goes to 1 for exactly one cycle after an edge with wr_en = 1 and busy[wr_sel] = 0 (value sampled before that edge's update). Otherwise wr_err is 0.
  - The write still completes; the error is advisory.
- No other state. wr_sel and set_sel are always in range (3-bit), so no out-of-range case exists.

Optional Feature:
- Macro: DEMUX16X8_WB_BYPASS_EN.
- Defined:
  - Each qn = (wr_en && wr_sel == n) ? write value (byte/word rules applied) : stored register.
  - This gives same-cycle write-through forwarding, so a read in the write cycle sees new data.
  - busy and wr_err timing are unchanged.
- Undefined: qn is purely the stored register; a read in the write cycle sees the old value.

Test Plan:
- Reset: assert reset asynchronously mid-cycle after writing 16'h1234 to R3 -> q3 = 16'h0000 and busy = 8'h00 immediately, before the next clk edge.
- Word write:
  - set_busy with set_sel=5, then next cycle wr_en, wr_sel=5, wr_data=16'hBEEF, wr_byte=0.
  - -> q5 = 16'hBEEF one cycle later; busy[5] goes 1 -> 0; other q unchanged; wr_err = 0.
- Byte write:
  - wr_sel=2, wr_data=16'h12F0, wr_byte=1 -> q2 = 16'hFFF0.
  - Then wr_data=16'hAB7F, wr_byte=1 -> q2 = 16'h007F.
- Collision:
  - R4 busy; same cycle set_busy with set_sel=4 and write to R4 with 16'h0042.
  - -> q4 = 16'h0042, busy[4] = 1, wr_err = 0.
- Error:
  - Write to R1 with busy[1] = 0, data 16'h0007.
  - -> q1 = 16'h0007 and wr_err pulses high for exactly one cycle.
- Sweep and bypass:
  - Write value 16'h1000+n to each R0..R7 in consecutive cycles -> q0..q7 end at 16'h1000..16'h1007.
  - With DEMUX16X8_WB_BYPASS_EN defined, q[n] shows 16'h1000+n in the same cycle as its write.
